// File: rtl/parity_stream_checker_pkg.sv
// Shared types and encodings for the streaming parity checker.
// Holds the FSM state encoding, the parity-mode codes and a helper to apply the mode.
package parity_stream_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic PAR_XOR  = 1'b0;
  localparam logic PAR_XNOR = 1'b1;

  // Turns a raw XOR accumulation into the parity selected for the frame.
  function automatic logic apply_sel(input logic acc, input logic sel);
    return (sel == PAR_XNOR) ? ~acc : acc;
  endfunction

endpackage

// File: rtl/parity_stream_checker_word_parity.sv
// Combinational XOR reduction of one data word.
module word_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/parity_stream_checker.sv
// Frame-level XOR/XNOR parity checker with valid/ready input and output ports.
// One registered result per frame; frames are force-closed at MAX_WORDS words.
module parity_stream_checker
  import parity_stream_checker_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_WORDS = 16,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parity_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_error,
  output logic             out_trunc,
  output logic [CNT_W-1:0] out_count
);

  // state | meaning
  // IDLE  | no frame open, next accepted word starts a frame
  // ACCUM | frame open, accumulating word parities
  // HOLD  | result presented, waiting for out_ready

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic             out_parity_q, out_parity_d;
  logic             out_error_q, out_error_d;
  logic             out_trunc_q, out_trunc_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             word_par;
  logic             accept;
  logic             first_word;
  logic             acc_new;
  logic             sel_eff;
  logic             par_new;
  logic [CNT_W-1:0] cnt_new;
  logic             close;

  word_parity #(.WIDTH(WIDTH)) u_word_parity (
    .data   (in_data),
    .parity (word_par)
  );

  assign in_ready   = (state_q != HOLD);
  assign accept     = in_valid && in_ready;
  assign first_word = (state_q == IDLE);
  assign acc_new    = first_word ? word_par : (acc_q ^ word_par);
  assign sel_eff    = first_word ? parity_sel : sel_q;
  assign cnt_new    = first_word ? CNT_W'(1) : (cnt_q + CNT_W'(1));
  assign par_new    = apply_sel(acc_new, sel_eff);
  assign close      = in_last || (cnt_new == MAX_CNT);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    out_valid_d  = out_valid_q;
    out_parity_d = out_parity_q;
    out_error_d  = out_error_q;
    out_trunc_d  = out_trunc_q;
    out_count_d  = out_count_q;

    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = acc_new;
          cnt_d = cnt_new;
          sel_d = sel_eff;
          if (close) begin
            state_d      = HOLD;
            out_valid_d  = 1'b1;
            out_parity_d = par_new;
            out_count_d  = cnt_new;
            out_trunc_d  = !in_last;
            // Truncated frames never carried an expected bit worth comparing.
            out_error_d  = in_last ? (par_new ^ in_exp) : 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          acc_d       = 1'b0;
          cnt_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      out_error_q  <= 1'b0;
      out_trunc_q  <= 1'b0;
      out_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      out_error_q  <= out_error_d;
      out_trunc_q  <= out_trunc_d;
      out_count_q  <= out_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_parity = out_parity_q;
  assign out_error  = out_error_q;
  assign out_trunc  = out_trunc_q;
  assign out_count  = out_count_q;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Self-checking bench: a WIDTH=8/MAX_WORDS=4 instance fed through a scoreboard,
// plus a WIDTH=3 instance exercised as the 3-input XNOR it replaces.
module tb_parity_stream_checker;

  localparam int MAXW = 4;

  typedef struct packed {
    logic       parity;
    logic       error;
    logic       trunc;
    logic [2:0] count;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       parity_sel = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       in_exp = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_parity;
  logic       out_error;
  logic       out_trunc;
  logic [2:0] out_count;

  logic       d3_sel = 1'b1;
  logic       d3_valid = 1'b0;
  logic       d3_ready;
  logic [2:0] d3_data = '0;
  logic       d3_last = 1'b1;
  logic       d3_exp = 1'b0;
  logic       d3_out_valid;
  logic       d3_out_ready = 1'b1;
  logic       d3_parity;
  logic       d3_error;
  logic       d3_trunc;
  logic [4:0] d3_count;

  int vectors = 0;
  int miscompares = 0;

  exp_t sb[$];
  logic       m_acc = 1'b0;
  logic       m_sel = 1'b0;
  int         m_cnt = 0;

  always #5 clk = ~clk;

  parity_stream_checker #(.WIDTH(8), .MAX_WORDS(MAXW)) u_dut (
    .clk(clk), .rst(rst), .parity_sel(parity_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_parity(out_parity),
    .out_error(out_error), .out_trunc(out_trunc), .out_count(out_count)
  );

  parity_stream_checker #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .parity_sel(d3_sel),
    .in_valid(d3_valid), .in_ready(d3_ready), .in_data(d3_data),
    .in_last(d3_last), .in_exp(d3_exp),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_parity(d3_parity),
    .out_error(d3_error), .out_trunc(d3_trunc), .out_count(d3_count)
  );

  // Result monitor: every completed output handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL result_unexpected: got p=%0b e=%0b t=%0b c=%0d with nothing expected",
                 out_parity, out_error, out_trunc, out_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({out_parity, out_error, out_trunc, out_count} !== e) begin
          miscompares++;
          $display("FAIL result: got p=%0b e=%0b t=%0b c=%0d want p=%0b e=%0b t=%0b c=%0d",
                   out_parity, out_error, out_trunc, out_count,
                   e.parity, e.error, e.trunc, e.count);
        end
      end
    end
  end

  // Reference model: called at the clock edge where a word is accepted.
  task automatic model_accept(input logic [7:0] d, input logic last, input logic exp,
                              input logic sel, output logic closed);
    exp_t e;
    logic p;
    if (m_cnt == 0) begin
      m_sel = sel;
      m_acc = ^d;
      m_cnt = 1;
    end else begin
      m_acc = m_acc ^ (^d);
      m_cnt = m_cnt + 1;
    end
    closed = last || (m_cnt == MAXW);
    if (closed) begin
      p = m_sel ? ~m_acc : m_acc;
      e.parity = p;
      e.trunc  = !last;
      e.error  = last ? (p ^ exp) : 1'b0;
      e.count  = 3'(m_cnt);
      sb.push_back(e);
      m_acc = 1'b0;
      m_cnt = 0;
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_acc = 1'b0;
    m_cnt = 0;
  endtask

  // Drives one word; called just after a rising edge, returns just after a rising edge.
  task automatic send_word(input logic [7:0] d, input logic last, input logic exp,
                           input logic sel);
    int   n;
    logic closed;
    in_data = d; in_last = last; in_exp = exp; parity_sel = sel; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(d, last, exp, sel, closed);
    #1 in_valid = 1'b0;
    if (closed) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL latency: out_valid=%0b one cycle after closing word, want 1", out_valid);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({out_valid, out_parity, out_error, out_trunc, out_count} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%0b p=%0b e=%0b t=%0b c=%0d want all 0",
               out_valid, out_parity, out_error, out_trunc, out_count);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_xnor3();
    logic [7:0] tbl;
    tbl = 8'b0110_1001;
    for (int d = 0; d < 8; d++) begin
      d3_data = 3'(d); d3_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if (d3_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL xnor3_ready: d=%0d got %0b want 1", d, d3_ready);
      end
      @(posedge clk);
      #1 d3_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (d3_out_valid !== 1'b1 || d3_parity !== tbl[d] || d3_count !== 5'd1) begin
        miscompares++;
        $display("FAIL xnor3: d=%0d got v=%0b p=%0b c=%0d want v=1 p=%0b c=1",
                 d, d3_out_valid, d3_parity, d3_count, tbl[d]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_single_word();
    send_word(8'hA5, 1'b1, 1'b0, 1'b0);
    send_word(8'hA5, 1'b1, 1'b0, 1'b1);
    send_word(8'h80, 1'b1, 1'b1, 1'b0);
    send_word(8'hFF, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_multi_word();
    send_word(8'h01, 1'b0, 1'b0, 1'b0);
    send_word(8'h03, 1'b0, 1'b0, 1'b1);
    send_word(8'h07, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_truncation();
    for (int i = 0; i < 4; i++) send_word(8'h01, 1'b0, 1'b1, 1'b0);
    send_word(8'h01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_word(8'h0F, 1'b0, 1'b0, 1'b1);
    send_word(8'h01, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    logic closed;
    out_ready = 1'b0;
    send_word(8'h03, 1'b1, 1'b1, 1'b0);
    in_data = 8'h07; in_last = 1'b1; in_exp = 1'b0; parity_sel = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_parity !== 1'b0 ||
          out_error !== 1'b1 || out_trunc !== 1'b0 || out_count !== 3'd1) begin
        miscompares++;
        $display("FAIL backpressure_hold: cyc=%0d got v=%0b rdy=%0b p=%0b e=%0b t=%0b c=%0d want v=1 rdy=0 p=0 e=1 t=0 c=1",
                 i, out_valid, in_ready, out_parity, out_error, out_trunc, out_count);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_release: got rdy=%0b v=%0b want 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    model_accept(8'h07, 1'b1, 1'b0, 1'b1, closed);
    #1 in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pending_word: out_valid=%0b after release, want 1", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      send_word(8'(i * 37 + 5), 1'b1, 1'(i), 1'(i >> 1));
  endtask

  task automatic test_reset_mid_frame();
    send_word(8'h01, 1'b0, 1'b0, 1'b0);
    send_word(8'h02, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_mid_frame: got v=%0b c=%0d want 0 0", out_valid, out_count);
    end
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    send_word(8'h80, 1'b1, 1'b0, 1'b0);

    out_ready = 1'b0;
    send_word(8'h01, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_hold: got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
    end
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send_word(8'h80, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_xnor3();
    test_single_word();
    test_multi_word();
    test_truncation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (3) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
